up_down_counter_p: RTL
======================

UP_DOWN_COUNTER_P -- requirements
Module: up_down_counter_p

Interface
REQ-001 Parameter WIDTH, 8, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, 0, end-of-range mode: 0 = wrap, 1 = saturate.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable; gates up/down only.
REQ-007 up  input  1  increment request.
REQ-008 down  input  1  decrement request.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value loaded on load.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 at_max  output  1  high while count == MAX_VAL; decoded from the count register.
REQ-013 at_min  output  1  high while count == 0; decoded from the count register.
REQ-014 wrap  output  1  registered one-cycle pulse on a wrap event.
REQ-015 sat  output  1  registered one-cycle pulse on a blocked step at a range end.

Function
REQ-016 Per-edge priority: load, then en with up XOR down, then hold.
REQ-017 load=1: count <= min(load_val, MAX_VAL) regardless of en/up/down; wrap=0, sat=0 next cycle.
REQ-018 load=0, en=0: count holds; wrap=0, sat=0.
REQ-019 en=1, up=1 and down=1 together: count holds, no pulse.
REQ-020 en=1, up only, count < MAX_VAL: count <= count+1.
REQ-021 en=1, down only, count > 0: count <= count-1.
REQ-022 Up at MAX_VAL:
  - SATURATE=0: count <= 0 and wrap=1 for one cycle.
  - SATURATE=1: count holds and sat=1 for one cycle.
REQ-023 Down at 0:
  - SATURATE=0: count <= MAX_VAL and wrap=1 for one cycle.
  - SATURATE=1: count holds and sat=1 for one cycle.
REQ-024 wrap and sat update on the same edge as the count update they describe, are never high together, and deassert the following cycle unless the event repeats.
REQ-025 Arithmetic is WIDTH bits unsigned; count never leaves 0..MAX_VAL, including when MAX_VAL < 2**WIDTH-1.
REQ-026 Latency: one clk edge from input sample to new count; at_max/at_min reflect count in the same cycle.

Reset
REQ-027 reset=1 forces count=0, wrap=0, sat=0 (and thr_hit=0 when configured) immediately, independent of clk.
REQ-028 While reset=1, all inputs are ignored; the first update occurs on the first rising clk edge after reset deasserts.
REQ-029 Reset asserted mid-count or mid-pulse clears state and pulses with no residual event after release.

Configuration
REQ-030 Macro UP_DOWN_COUNTER_P_THRESH_EN defined: adds port thresh (input, WIDTH) and port thr_hit (output, 1).
REQ-031 With UP_DOWN_COUNTER_P_THRESH_EN defined:
  - thr_hit is sticky; it sets on the edge where the updated count equals thresh via count or wrap.
  - It clears on load or reset; load of a value equal to thresh does not set it.
REQ-032 Macro undefined: thresh and thr_hit ports are absent; all other behaviour is identical.

Verification
REQ-033 WIDTH=4, MAX_VAL=9, SATURATE=0: reset, then en=1, up=1 for 10 edges -> count 1..9, then 0, with wrap=1 only on the 10th edge.
REQ-034 SATURATE=1, count=0, en=1, down=1 for 2 edges -> count stays 0, sat=1 on both edges, at_min=1 throughout.
REQ-035 load=1, load_val=15 with MAX_VAL=9, en=1, up=1 in the same cycle -> count=9, at_max=1, no pulse.
REQ-036 count=5, en=1, up=1, down=1 -> count stays 5; then en=0, up=1 -> count stays 5.
REQ-037 count=7, wrap pulse in flight, reset asserted between edges -> count=0 and wrap=0 immediately; no pulse after release.
REQ-038 THRESH_EN defined, thresh=3, count from 0 up -> thr_hit rises on the edge count becomes 3, stays 1 through count 4..9, clears on load.

Source files
------------

// File: rtl/up_down_counter_p.sv
// up_down_counter_p: up/down counter with synchronous load, wrap or saturate within 0..MAX_VAL.
// Define UP_DOWN_COUNTER_P_THRESH_EN to add the thresh input and the sticky thr_hit output.
module up_down_counter_p #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UP_DOWN_COUNTER_P_THRESH_EN
  input  logic [WIDTH-1:0] thresh,
  output logic             thr_hit,
`endif
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);
  logic [WIDTH-1:0] next_count;
  logic next_wrap, next_sat, step_up, step_dn;
  assign step_up = en & up & ~down;
  assign step_dn = en & down & ~up;
  assign at_max = count == MAX_VAL;
  assign at_min = count == '0;
  // Next value: load wins, then a single-direction step; range ends wrap or block depending on SATURATE
  always_comb begin
    next_count = count;
    next_wrap = 1'b0;
    next_sat = 1'b0;
    if (load) next_count = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    else if (step_up && count >= MAX_VAL) begin
      next_count = SATURATE ? count : '0;
      next_wrap = !SATURATE;
      next_sat = SATURATE;
    end else if (step_up) next_count = count + 1'b1;
    else if (step_dn && count == '0) begin
      next_count = SATURATE ? count : MAX_VAL;
      next_wrap = !SATURATE;
      next_sat = SATURATE;
    end else if (step_dn) next_count = count - 1'b1;
  end
  // Count register and one-cycle event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap <= 1'b0;
      sat <= 1'b0;
    end else begin
      count <= next_count;
      wrap <= next_wrap;
      sat <= next_sat;
    end
  end
`ifdef UP_DOWN_COUNTER_P_THRESH_EN
  logic moved;
  assign moved = ~load & (step_up | step_dn) & ~next_sat;
  // Sticky flag: set only when a real step (count or wrap) lands on thresh; load clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_hit <= 1'b0;
    else thr_hit <= load ? 1'b0 : (thr_hit | (moved & (next_count == thresh)));
  end
`endif
endmodule
